speed_gen: RTL
==============

# speed_gen

Rate-controlled pulse source: the transmit-side counterpart of the per-millisecond throughput meter. It converts a programmed byte rate per 1 ms window into exactly N = floor(rate / B1) single-cycle pulses, spread evenly across each 30720-cycle window. It drives the meter's increment input in loopback tests and paces test traffic in the modem datapath.

## Interface
- B1, 1920: bytes represented by one pulse.
- WINDOW, 30720: window length in clk cycles (1 ms at 30.72 MHz).
- clk  in  1  30.72 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- rate_in  in  18  requested bytes per window.
- rate_valid  in  1  one-cycle load strobe for rate_in.
- enable  in  1  generation enable; sampled at window start.
- p_out  out  1  one-cycle pulse, each worth B1 bytes.
- win_strobe  out  1  one-cycle marker of window start.
- n_active  out  8  pulses per window currently in effect.
- div_busy  out  1  divider is computing a new N.

## Operation
- Reset values: p_out, win_strobe, div_busy = 0; n_active = 0. Internal timer, phase accumulator, pending N and the latched enable are also 0.
- Timer runs 0..WINDOW-1 and wraps. It runs continuously regardless of enable.
- Divider:
  - On rate_valid, latch rate_in as rem, set q = 0, assert div_busy.
  - Each busy cycle: if rem >= B1, then rem -= B1 and q += 1. Otherwise store n_pend = q, set pend_flag, and drop div_busy.
- At timer == 0:
  - If pend_flag is set, n_active <= n_pend and pend_flag is cleared.
  - en_act <= enable.
  - The phase accumulator is cleared.
- Each cycle with en_act = 1:
  - sum = acc + n_active.
  - If sum >= WINDOW, pulse and acc <= sum - WINDOW; otherwise acc <= sum.
  - Result: exactly n_active pulses per window, the k-th one at timer = ceil(k·WINDOW/n_active) - 1.
- Arithmetic widths: acc is 16 bits (max WINDOW + 136 fits). q/N is 8 bits; N is at most 136 for an 18-bit rate.
- Truncation: any remainder below B1 is discarded silently.
- Boundary conditions:
  - rate_valid while div_busy: restart the divider with the new value; the latest value wins and the previous pending result is discarded.
  - Divider finishes on the cycle where timer == 0: the result is not applied until the next window.
  - rate_in = 0 or rate_in < B1: N = 0, no pulses.
  - enable change mid-window: no effect until the next timer == 0.
  - Reset mid-operation: all outputs drop to 0 immediately (asynchronous), and the timer restarts from 0 on release.

## Timing
- p_out and win_strobe are registered.
- p_out asserts in the cycle after the timer value at which the pulse condition is met.
- win_strobe asserts in the cycle after timer == 0.
- Divider latency: N + 1 cycles from the rate_valid capture to pend_flag.
- Worst-case divider latency is 137 cycles, well under WINDOW.
- New rate takes effect at the first window start after pend_flag.
- Minimum pulse spacing is floor(WINDOW/136) = 225 cycles. This is compatible with the meter's 9-cycle pulse stretch.

## Structure
- Shared package speed_pkg holds:
  - B1 default and WINDOW;
  - TIMER_MAX = WINDOW-1;
  - N_W = 8 and RATE_W = 18.
- The meter also uses this package.
- Sub-module rate_div: sequential repeated-subtraction divider by B1, with start/busy/done/q ports.
- The top level holds the timer, the window-boundary apply logic and the phase accumulator.

## Test plan
- rate_in = 30720, enable = 1 → after divider done and the next window, n_active = 16. 16 pulses per window, following the timer = 1919 + 1920k rule (k = 0..15); the final pulse is at timer = 30719.
- rate_in = 1919, then 0 → n_active = 0 and no p_out over 2 windows; win_strobe still pulses every 30720 cycles.
- rate_in = 262143 → div_busy for 137 cycles, n_active = 136, exactly 136 pulses per window, minimum spacing ≥ 225 cycles.
- Back-to-back rate_valid (3840 then 5760 one cycle apart) mid-window → old N is kept until the boundary, then n_active = 3; 3840 is never applied.
- enable falls mid-window → the current window still emits all N pulses; the next window emits none.
- Assert reset at timer ≈ 15000 with N = 16 → outputs 0 the same cycle. After release, n_active = 0 until a new rate_valid.
- Loopback into the meter with rate_in = 30720 → meter reports 30720 every window after settling.

Source files
------------

// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared constants for the rate pulse source and throughput meter
// Purpose: pulse worth (B1), window length and datapath widths used by
//          speed_gen, its divider and the per-millisecond meter.
// Ports:   none (package).
package speed_pkg;

    localparam int unsigned B1        = 1920;            // bytes per pulse
    localparam int unsigned WINDOW    = 30720;           // clk cycles per 1 ms window
    localparam int unsigned TIMER_MAX = WINDOW - 1;
    localparam int unsigned N_W       = 8;               // pulses per window, max 136
    localparam int unsigned RATE_W    = 18;              // requested bytes per window
    localparam int unsigned TIMER_W   = $clog2(WINDOW);  // 15 bits cover 0..30719
    localparam int unsigned ACC_W     = 16;              // holds WINDOW + max N

endpackage

// File: rtl/speed_gen_if.sv
// rtl/speed_gen_if.sv - rate load / pulse output bundle of speed_gen
// Purpose: groups rate programming, enable and generated outputs.
// Signals: rate_in/rate_valid/enable (to generator), p_out/win_strobe/
//          n_active/div_busy (from generator).
// Modports: master = rate programmer, slave = speed_gen.
interface speed_gen_if;
    import speed_pkg::*;

    logic [RATE_W-1:0] rate_in;
    logic              rate_valid;
    logic              enable;
    logic              p_out;
    logic              win_strobe;
    logic [N_W-1:0]    n_active;
    logic              div_busy;

    modport master (
        output rate_in, rate_valid, enable,
        input  p_out, win_strobe, n_active, div_busy
    );

    modport slave (
        input  rate_in, rate_valid, enable,
        output p_out, win_strobe, n_active, div_busy
    );

endinterface

// File: rtl/speed_gen_rate_div.sv
// rtl/speed_gen_rate_div.sv - repeated-subtraction divider by a constant
// Purpose: computes q = floor(rate / DIVISOR), one subtraction per cycle.
// Ports:   clk, reset     clock, async active-high reset
//          start_i/rate_i load strobe and dividend (restarts a busy divide)
//          busy_o         divide in progress
//          done_o         single-cycle, combinational: q_o is final this cycle
//          q_o            quotient
module rate_div
    import speed_pkg::*;
#(
    parameter int unsigned DIVISOR = B1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_W-1:0]    q_o
);

    localparam logic [RATE_W-1:0] DIV_V = RATE_W'(DIVISOR);

    logic [RATE_W-1:0] rem_q, rem_d;
    logic [N_W-1:0]    q_q, q_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            q_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            q_q    <= q_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rem_d  = rem_q;
        q_d    = q_q;
        busy_d = busy_q;
        // A new start always wins, so the latest programmed rate is the one divided.
        if (start_i) begin
            rem_d  = rate_i;
            q_d    = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= DIV_V) begin
                rem_d = rem_q - DIV_V;
                q_d   = q_q + 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (rem_q < DIV_V);
    assign q_o    = q_q;

endmodule

// File: rtl/speed_gen.sv
// rtl/speed_gen.sv - rate-controlled pulse source, N evenly spaced pulses per window
// Purpose: converts bytes-per-window into N = floor(rate/B1) single-cycle
//          pulses spread across each WINDOW-cycle window.
// Ports:   clk   system clock
//          reset asynchronous active-high reset
//          bus   speed_gen_if.slave (rate_in, rate_valid, enable in;
//                p_out, win_strobe, n_active, div_busy out)
module speed_gen
    import speed_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    speed_gen_if.slave  bus
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_MAX);
    localparam logic [ACC_W-1:0]   WIN_V      = ACC_W'(WINDOW);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]     n_active_q, n_active_d;
    logic [N_W-1:0]     n_pend_q, n_pend_d;
    logic               pend_q, pend_d;
    logic               en_act_q, en_act_d;
    logic               p_out_q, p_out_d;
    logic               win_q, win_d;

    logic               div_busy;
    logic               div_done;
    logic [N_W-1:0]     div_q;
    logic               win_start;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   sum;

    rate_div #(
        .DIVISOR (B1)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start_i (bus.rate_valid),
        .rate_i  (bus.rate_in),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .q_o     (div_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q    <= '0;
            acc_q      <= '0;
            n_active_q <= '0;
            n_pend_q   <= '0;
            pend_q     <= 1'b0;
            en_act_q   <= 1'b0;
            p_out_q    <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            n_active_q <= n_active_d;
            n_pend_q   <= n_pend_d;
            pend_q     <= pend_d;
            en_act_q   <= en_act_d;
            p_out_q    <= p_out_d;
            win_q      <= win_d;
        end
    end

    always_comb begin
        win_start = (timer_q == '0);
        timer_d   = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
        win_d     = win_start;

        n_active_d = n_active_q;
        en_act_d   = en_act_q;
        n_pend_d   = n_pend_q;
        pend_d     = pend_q;

        // Window boundary: only a result already pending by now is applied; a
        // divide finishing in this very cycle waits for the next boundary.
        if (win_start) begin
            if (pend_q) begin
                n_active_d = n_pend_q;
                pend_d     = 1'b0;
            end
            en_act_d = bus.enable;
        end

        // A reload discards any result not yet applied.
        if (bus.rate_valid) begin
            pend_d = 1'b0;
        end else if (div_done) begin
            pend_d   = 1'b1;
            n_pend_d = div_q;
        end

        // The boundary cycle already accumulates from zero with the new N and
        // enable, which places the k-th pulse at timer = ceil(k*WINDOW/N) - 1.
        acc_base = win_start ? '0 : acc_q;
        sum      = acc_base + ACC_W'(n_active_d);
        p_out_d  = 1'b0;
        acc_d    = acc_base;
        if (en_act_d) begin
            if (sum >= WIN_V) begin
                p_out_d = 1'b1;
                acc_d   = sum - WIN_V;
            end else begin
                acc_d = sum;
            end
        end
    end

    assign bus.p_out      = p_out_q;
    assign bus.win_strobe = win_q;
    assign bus.n_active   = n_active_q;
    assign bus.div_busy   = div_busy;

endmodule
